// File: rtl/pulse_width_detector_if.sv
// -----------------------------------------------------------------------------
// pulse_width_detector_if
// Signal bundle between the pulse-width detector and whatever drives it.
//   a        : per-channel input samples
//   pol      : per-channel pulse polarity (1 = high pulse, 0 = low pulse)
//   rise     : one-cycle rising-edge flag per channel
//   fall     : one-cycle falling-edge flag per channel
//   detected : one-cycle accepted-pulse flag per channel
//   width    : per-channel active-sample count, channel i at [i*CNT_W +: CNT_W]
// Modports: master drives a/pol and observes results; slave is the detector.
// -----------------------------------------------------------------------------
interface pulse_width_detector_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
);
  logic [CHANNELS-1:0]       a;
  logic [CHANNELS-1:0]       pol;
  logic [CHANNELS-1:0]       rise;
  logic [CHANNELS-1:0]       fall;
  logic [CHANNELS-1:0]       detected;
  logic [CHANNELS*CNT_W-1:0] width;

  modport master (output a, pol, input rise, fall, detected, width);
  modport slave  (input a, pol, output rise, fall, detected, width);
endinterface

// File: rtl/pulse_width_detector.sv
// -----------------------------------------------------------------------------
// pulse_width_detector
// Per-channel pulse-width measurement. A pulse is a run of "active" samples
// (a == pol) bounded by inactive samples. The run length is counted and a
// one-cycle detected flag is raised on the trailing edge when the length lies
// in [MIN_WIDTH, MAX_WIDTH]. Rise/fall flags report raw edges of the sample.
//
// Ports:
//   clk : clock, all state on posedge
//   rst : synchronous, active-high reset
//   bus : pulse_width_detector_if.slave (a, pol in; rise, fall, detected,
//         width out)
//
// Optional build macro PULSE_WIDTH_DETECTOR_SYNC_EN: inserts a two-flop
// synchronizer (reset to 0) on every a bit, delaying all outputs by 2 cycles.
// -----------------------------------------------------------------------------
module pulse_width_detector #(
  parameter int CHANNELS  = 4,
  parameter int CNT_W     = 8,
  parameter int MIN_WIDTH = 1,
  parameter int MAX_WIDTH = 1
) (
  input logic                     clk,
  input logic                     rst,
  pulse_width_detector_if.slave   bus
);

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_WIDTH);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WIDTH);

  // Counter increment that sticks at all-ones; a stuck counter is above
  // MAX_WIDTH by construction, so it can never be accepted.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic in_window(input logic [CNT_W-1:0] v);
    return (v != '0) && (v >= MIN_C) && (v <= MAX_C);
  endfunction

  logic [CHANNELS-1:0] a_s;

`ifdef PULSE_WIDTH_DETECTOR_SYNC_EN
  logic [CHANNELS-1:0] sync1_q;
  logic [CHANNELS-1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.a;
      sync2_q <= sync1_q;
    end
  end

  assign a_s = sync2_q;
`else
  assign a_s = bus.a;
`endif

  logic [CHANNELS-1:0] a_r_q;
  logic [CHANNELS-1:0] pol_r_q;
  logic [CHANNELS-1:0] pv_q;
  logic [CHANNELS-1:0] armed_q;
  logic [CHANNELS-1:0] armed_d;
  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];

  logic [CHANNELS-1:0] act_c;
  logic [CHANNELS-1:0] pact_c;
  logic [CHANNELS-1:0] pchg_c;
  logic [CHANNELS-1:0] lead_c;
  logic [CHANNELS-1:0] trail_c;
  logic [CHANNELS-1:0] det_c;
  logic [CHANNELS*CNT_W-1:0] width_c;

  // Previous-sample activity uses the polarity that was in force at the time;
  // a polarity change is only meaningful once a previous sample exists.
  assign act_c   = ~(a_s ^ bus.pol);
  assign pact_c  = pv_q & ~(a_r_q ^ pol_r_q);
  assign pchg_c  = pv_q & (bus.pol ^ pol_r_q);
  assign lead_c  = ~pact_c & act_c;
  assign trail_c = pact_c & ~act_c;

  always_comb begin
    armed_d = armed_q;
    cnt_d   = cnt_q;
    det_c   = '0;
    width_c = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      det_c[i] = ~pchg_c[i] & trail_c[i] & in_window(cnt_q[i]);
      width_c[i*CNT_W +: CNT_W] = rst ? '0 : cnt_q[i];
      if (pchg_c[i]) begin
        // Polarity switch abandons any run in progress; re-arm needs a fresh
        // inactive sample under the new polarity.
        armed_d[i] = 1'b0;
        cnt_d[i]   = '0;
      end else if (act_c[i]) begin
        if (lead_c[i] && armed_q[i]) begin
          cnt_d[i] = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (cnt_q[i] != '0) begin
          cnt_d[i] = sat_inc(cnt_q[i]);
        end
      end else begin
        armed_d[i] = 1'b1;
        cnt_d[i]   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r_q   <= '0;
      pol_r_q <= '0;
      pv_q    <= '0;
      armed_q <= '0;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
    end else begin
      a_r_q   <= a_s;
      pol_r_q <= bus.pol;
      pv_q    <= '1;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.rise     = pv_q & ~a_r_q & a_s & {CHANNELS{~rst}};
  assign bus.fall     = pv_q & a_r_q & ~a_s & {CHANNELS{~rst}};
  assign bus.detected = det_c & {CHANNELS{~rst}};
  assign bus.width    = width_c;

endmodule

// File: tb/tb_pulse_width_detector.sv
module tb_pulse_width_detector;

  localparam int NCH  = 4;
  localparam int NDUT = 4;
  localparam int CW   [NDUT] = '{8, 4, 3, 8};
  localparam int MINW [NDUT] = '{1, 3, 1, 1};
  localparam int MAXW [NDUT] = '{1, 5, 6, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  pulse_width_detector_if #(.CHANNELS(4), .CNT_W(8)) if0 ();
  pulse_width_detector_if #(.CHANNELS(4), .CNT_W(4)) if1 ();
  pulse_width_detector_if #(.CHANNELS(4), .CNT_W(3)) if2 ();
  pulse_width_detector_if #(.CHANNELS(4), .CNT_W(8)) if3 ();

  pulse_width_detector #(.CHANNELS(4), .CNT_W(8), .MIN_WIDTH(1), .MAX_WIDTH(1))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  pulse_width_detector #(.CHANNELS(4), .CNT_W(4), .MIN_WIDTH(3), .MAX_WIDTH(5))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  pulse_width_detector #(.CHANNELS(4), .CNT_W(3), .MIN_WIDTH(1), .MAX_WIDTH(6))
    dut2 (.clk(clk), .rst(rst), .bus(if2));
  pulse_width_detector #(.CHANNELS(4), .CNT_W(8), .MIN_WIDTH(1), .MAX_WIDTH(2))
    dut3 (.clk(clk), .rst(rst), .bus(if3));

  // Reference model: for each channel, the length of the current active run,
  // whether that run qualifies (it began right after an inactive sample seen
  // since the last reset / polarity switch), plus the previous sample.
  bit m_pv   [NDUT][NCH];
  bit m_ps   [NDUT][NCH];
  bit m_pp   [NDUT][NCH];
  bit m_seen [NDUT][NCH];
  bit m_ok   [NDUT][NCH];
  int m_len  [NDUT][NCH];
  bit s1 [NCH];
  bit s2 [NCH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [3:0] av, input logic [3:0] pv, input bit r);
    logic [3:0] ro [NDUT];
    logic [3:0] fo [NDUT];
    logic [3:0] dout [NDUT];
    logic [31:0] wo [NDUT][NCH];
    @(negedge clk);
    rst = r;
    if0.a = av; if1.a = av; if2.a = av; if3.a = av;
    if0.pol = pv; if1.pol = pv; if2.pol = pv; if3.pol = pv;
    #1;
    ro[0] = if0.rise; fo[0] = if0.fall; dout[0] = if0.detected;
    ro[1] = if1.rise; fo[1] = if1.fall; dout[1] = if1.detected;
    ro[2] = if2.rise; fo[2] = if2.fall; dout[2] = if2.detected;
    ro[3] = if3.rise; fo[3] = if3.fall; dout[3] = if3.detected;
    for (int c = 0; c < NCH; c++) begin
      wo[0][c] = 32'(if0.width[c*8 +: 8]);
      wo[1][c] = 32'(if1.width[c*4 +: 4]);
      wo[2][c] = 32'(if2.width[c*3 +: 3]);
      wo[3][c] = 32'(if3.width[c*8 +: 8]);
    end
    for (int d = 0; d < NDUT; d++) begin
      logic [3:0] er, ef, ed;
      int ew [NCH];
      er = '0; ef = '0; ed = '0;
      for (int c = 0; c < NCH; c++) begin
        bit s, p, act, pact, pchg;
        int sat;
        ew[c] = 0;
`ifdef PULSE_WIDTH_DETECTOR_SYNC_EN
        s = s2[c];
`else
        s = av[c];
`endif
        p = pv[c];
        if (r) begin
          m_pv[d][c] = 0; m_ps[d][c] = 0; m_pp[d][c] = 0;
          m_seen[d][c] = 0; m_ok[d][c] = 0; m_len[d][c] = 0;
        end else begin
          act  = (s == p);
          pact = m_pv[d][c] && (m_ps[d][c] == m_pp[d][c]);
          pchg = m_pv[d][c] && (p != m_pp[d][c]);
          sat  = (1 << CW[d]) - 1;
          ew[c] = m_ok[d][c] ? ((m_len[d][c] > sat) ? sat : m_len[d][c]) : 0;
          er[c] = m_pv[d][c] && !m_ps[d][c] && s;
          ef[c] = m_pv[d][c] && m_ps[d][c] && !s;
          ed[c] = !pchg && pact && !act && ew[c] != 0 && ew[c] >= MINW[d] && ew[c] <= MAXW[d];
          if (pchg) begin
            m_seen[d][c] = 0; m_ok[d][c] = 0; m_len[d][c] = 0;
          end else if (act) begin
            if (!pact && m_seen[d][c]) begin
              m_ok[d][c] = 1; m_len[d][c] = 1;
            end else if (m_ok[d][c] && m_len[d][c] < 1000) begin
              m_len[d][c]++;
            end
          end else begin
            m_seen[d][c] = 1; m_ok[d][c] = 0; m_len[d][c] = 0;
          end
          m_pv[d][c] = 1; m_ps[d][c] = s; m_pp[d][c] = p;
        end
      end
      chk($sformatf("d%0d.rise", d), 32'(ro[d]), 32'(er));
      chk($sformatf("d%0d.fall", d), 32'(fo[d]), 32'(ef));
      chk($sformatf("d%0d.detected", d), 32'(dout[d]), 32'(ed));
      for (int c = 0; c < NCH; c++)
        chk($sformatf("d%0d.width[%0d]", d, c), wo[d][c], 32'(ew[c]));
    end
    for (int c = 0; c < NCH; c++) begin
      if (r) begin
        s1[c] = 0; s2[c] = 0;
      end else begin
        s2[c] = s1[c]; s1[c] = av[c];
      end
    end
  endtask

  initial begin
    logic [3:0] ra, rp;
    int lens [4];
    if0.a = '0; if1.a = '0; if2.a = '0; if3.a = '0;
    if0.pol = '1; if1.pol = '1; if2.pol = '1; if3.pol = '1;
    lens = '{2, 3, 5, 6};

    // Reset and idle
    step(4'h0, 4'hF, 1); step(4'h0, 4'hF, 1);
    step(4'h0, 4'hF, 0); step(4'h0, 4'hF, 0);

    // 010 on every channel
    step(4'hF, 4'hF, 0); step(4'h0, 4'hF, 0);
`ifndef PULSE_WIDTH_DETECTOR_SYNC_EN
    chk("req037.det", 32'(if0.detected), 32'hF);
    chk("req032.width0", 32'(if0.width[7:0]), 32'd1);
`endif
    // 0110 must not be accepted with MAX_WIDTH=1
    step(4'hF, 4'hF, 0); step(4'hF, 4'hF, 0); step(4'h0, 4'hF, 0);
`ifndef PULSE_WIDTH_DETECTOR_SYNC_EN
    chk("req032.det_two", 32'(if0.detected), 32'h0);
`endif

    // Pulses of 2,3,5,6 against window [3,5]
    foreach (lens[k]) begin
      repeat (lens[k]) step(4'hF, 4'hF, 0);
      step(4'h0, 4'hF, 0);
`ifndef PULSE_WIDTH_DETECTOR_SYNC_EN
      chk($sformatf("req033.det_len%0d", lens[k]), 32'(if1.detected),
          (lens[k] == 3 || lens[k] == 5) ? 32'hF : 32'h0);
      chk($sformatf("req033.width_len%0d", lens[k]), 32'(if1.width[3:0]), 32'(lens[k]));
`endif
      step(4'h0, 4'hF, 0);
    end

    // 20-cycle pulse saturates a 3-bit counter
    repeat (20) step(4'hF, 4'hF, 0);
    step(4'h0, 4'hF, 0);
`ifndef PULSE_WIDTH_DETECTOR_SYNC_EN
    chk("req034.fall", 32'(if2.fall), 32'hF);
    chk("req034.det", 32'(if2.detected), 32'h0);
    chk("req034.width_sat", 32'(if2.width[2:0]), 32'd7);
`endif

    // Low pulse on ch2
    step(4'h4, 4'hB, 0); step(4'h4, 4'hB, 0);
    step(4'h0, 4'hB, 0); step(4'h0, 4'hB, 0);
    step(4'h4, 4'hB, 0);
`ifndef PULSE_WIDTH_DETECTOR_SYNC_EN
    chk("req035.det2", 32'(if3.detected[2]), 32'd1);
    chk("req035.width2", 32'(if3.width[23:16]), 32'd2);
    chk("req035.rise2", 32'(if3.rise[2]), 32'd1);
`endif
    step(4'h0, 4'hF, 0); step(4'h0, 4'hF, 0);

    // Active level held through reset release
    step(4'hF, 4'hF, 1); step(4'hF, 4'hF, 1);
    step(4'hF, 4'hF, 0); step(4'hF, 4'hF, 0); step(4'hF, 4'hF, 0);
    step(4'h0, 4'hF, 0);
`ifndef PULSE_WIDTH_DETECTOR_SYNC_EN
    chk("req036.det_after_rst", 32'(if0.detected), 32'h0);
    chk("req036.fall_after_rst", 32'(if0.fall), 32'hF);
`endif
    // Polarity toggled mid-pulse
    step(4'h0, 4'hF, 0); step(4'hF, 4'hF, 0);
    step(4'hF, 4'h0, 0);
`ifndef PULSE_WIDTH_DETECTOR_SYNC_EN
    chk("req036.det_polchg", 32'(if0.detected), 32'h0);
`endif
    step(4'hF, 4'h0, 0); step(4'h0, 4'h0, 0); step(4'hF, 4'h0, 0);
    step(4'hF, 4'hF, 0); step(4'h0, 4'hF, 0); step(4'h0, 4'hF, 0);

    // Reset in the middle of a pulse
    step(4'hF, 4'hF, 0); step(4'hF, 4'hF, 1);
    step(4'hF, 4'hF, 0); step(4'h0, 4'hF, 0);
`ifndef PULSE_WIDTH_DETECTOR_SYNC_EN
    chk("req037.det_rst_mid", 32'(if3.detected), 32'h0);
`endif
    step(4'h0, 4'hF, 0);

    // Randomized traffic
    ra = 4'h0; rp = 4'hF;
    for (int n = 0; n < 800; n++) begin
      bit rr;
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(2) == 0) ra[c] = ~ra[c];
        if ($urandom_range(60) == 0) rp[c] = ~rp[c];
      end
      rr = ($urandom_range(120) == 0);
      step(ra, rp, rr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pulse_width_detector.md
PULSE_WIDTH_DETECTOR -- requirements
Module: pulse_width_detector

Interface
REQ-001 SHALL have parameter CHANNELS, default 4, number of independent input channels (>=1).
REQ-002 SHALL have parameter CNT_W, default 8, width of each per-channel pulse-width counter (>=2).
REQ-003 SHALL have parameter MIN_WIDTH, default 1, shortest accepted pulse in cycles.
REQ-004 SHALL have parameter MAX_WIDTH, default 1, longest accepted pulse in cycles; legal only when 1 <= MIN_WIDTH <= MAX_WIDTH <= 2^CNT_W-2.
REQ-005 SHALL have ports: clk  in  1  clock, all state on posedge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 a  in  CHANNELS  per-channel input samples.
REQ-008 pol  in  CHANNELS  per-channel pulse polarity; 1 = high pulse (0-1..1-0), 0 = low pulse (1-0..0-1).
REQ-009 rise  out  CHANNELS  one-cycle rising-edge flag.
REQ-010 fall  out  CHANNELS  one-cycle falling-edge flag.
REQ-011 detected  out  CHANNELS  one-cycle accepted-pulse flag.
REQ-012 width  out  CHANNELS*CNT_W  per-channel active-sample count, channel i at bits [i*CNT_W +: CNT_W].

Function
REQ-013 Per channel SHALL register previous sample a_r, previous polarity pol_r, prev_valid, armed, and counter cnt.
REQ-014 "Active" sample SHALL mean a[i] == pol[i]; leading edge = previous sample inactive, current active; trailing edge = previous active, current inactive.
REQ-015 rise[i] SHALL = prev_valid & ~a_r & a[i]; fall[i] SHALL = prev_valid & a_r & ~a[i]; both combinational, zero latency, polarity-independent.
REQ-016 prev_valid SHALL set on the first clock after reset deassertion and stay set.
REQ-017 armed SHALL set on any clock with an inactive current sample; SHALL clear only by reset or polarity change.
REQ-018 On a clock with an active sample: leading edge with armed=1 -> cnt <= 1; otherwise, if cnt != 0 -> cnt <= min(cnt+1, 2^CNT_W-1) (saturating).
REQ-019 On a clock with an inactive sample, cnt SHALL load 0.
REQ-020 detected[i] SHALL = trailing edge & cnt != 0 & MIN_WIDTH <= cnt <= MAX_WIDTH; combinational, asserted in the cycle the input returns inactive.
REQ-021 Saturated cnt (2^CNT_W-1) SHALL never produce detected.
REQ-022 width slice i SHALL equal cnt of channel i; valid for the pulse whenever detected[i]=1.
REQ-023 Active level present at/after reset without a preceding inactive sample SHALL NOT be counted or detected (cnt stays 0).
REQ-024 If pol[i] != pol_r in a cycle: channel i detected SHALL be 0, armed and cnt SHALL clear on that clock, then re-arm per REQ-017.
REQ-025 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be reported in the same cycle.
REQ-026 Defaults with pol=1 SHALL reproduce exact 010 single-cycle-pulse detection.

Reset
REQ-027 rst=1 SHALL clear a_r, pol_r, prev_valid, armed, cnt of every channel on the next posedge.
REQ-028 While rst=1 or in the first cycle after it: rise, fall, detected SHALL be 0; width SHALL be 0.
REQ-029 Reset mid-pulse SHALL discard the pulse; no detected on its trailing edge.

Configuration
REQ-030 Macro PULSE_WIDTH_DETECTOR_SYNC_EN, when defined, SHALL insert a two-flop synchronizer (reset to 0) on every a bit ahead of all logic, adding exactly 2 cycles latency to every output.
REQ-031 Without the macro, a SHALL feed the logic directly with latencies as in REQ-015/REQ-020.

Verification
REQ-032 Defaults, pol=1, ch0 a = 0,1,0 -> detected[0]=1 in cycle of the 0, width[0]=1; a = 0,1,1,0 -> no detected.
REQ-033 MIN=3, MAX=5, CNT_W=4: high pulses of 2,3,5,6 cycles -> detected only for 3 and 5, width 3 and 5.
REQ-034 CNT_W=3, MIN=1, MAX=6: high pulse 20 cycles -> cnt saturates at 7, no detected, fall=1 at end.
REQ-035 pol=0, ch2 a = 1,0,0,1 with MIN=1, MAX=2 -> detected[2]=1, width=2, rise[2]=1 same cycle.
REQ-036 a=1 held through reset release then 0 -> no detected, fall=1; pol toggled mid-pulse -> no detected.
REQ-037 All 4 channels 010 in same cycle -> detected=4'b1111; rst asserted mid-pulse -> no detected after.
